// File: rtl/sum_rr_sched_if.sv
// Request/data lanes from the producers and grant/tagged-sum results back.
// DUT side uses the slave modport; the driving side uses master.
interface sum_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int SW   = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] d_in;
  logic [NREQ-1:0]    gnt;
  logic               d_ack;
  logic [SW-1:0]      sum;
  logic [IW-1:0]      sum_id;
  logic               sum_valid;
  logic               sum_ovf;
  logic               ready;

  modport master (
    output req, d_in,
    input  gnt, d_ack, sum, sum_id, sum_valid, sum_ovf, ready
  );

  modport slave (
    input  req, d_in,
    output gnt, d_ack, sum, sum_id, sum_valid, sum_ovf, ready
  );
endinterface

// File: rtl/sum_rr_sched.sv
// sum_rr_sched: round-robin share of one NSAMP-sample accumulator; sum_valid NSAMP+1 cycles after request.
// Results are a one-cycle strobe (no backpressure); define SUM_SAT_EN to saturate instead of wrap.
module sum_rr_sched #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int NSAMP = 4,
  parameter int SW    = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  sum_rr_sched_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [SW-1:0]   acc_q,     acc_d;
  logic            ovf_q,     ovf_d;
  logic [IW-1:0]   ptr_q,     ptr_d;
  logic [IW-1:0]   win_q,     win_d;
  logic [SW-1:0]   sum_q,     sum_d;
  logic [IW-1:0]   sum_id_q,  sum_id_d;
  logic            sum_ovf_q, sum_ovf_d;

  logic            found;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   ptr_next;
  logic [NREQ-1:0] winner_oh;
  logic            win_req;
  logic [DW-1:0]   lane;
  logic [SW-1:0]   lane_ext;
  logic [SW-1:0]   acc_base;
  logic [SW-1:0]   add_res;
  logic            carry;
  logic [SW-1:0]   acc_next;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    winner   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    int p;
    p         = int'(winner) + 1;
    if (p >= NREQ) p = 0;
    ptr_next  = IW'(p);
    winner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) winner_oh[i] = 1'b1;
    end
  end

  always_comb begin
    lane    = '0;
    win_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == IW'(i)) begin
        lane    = bus.d_in[i*DW +: DW];
        win_req = bus.req[i];
      end
    end
  end

  // First sample of a transaction starts from zero rather than the stale accumulator.
  always_comb begin
    lane_ext           = '0;
    lane_ext[DW-1:0]   = lane;
    acc_base           = (cnt_q == '0) ? '0 : acc_q;
    {carry, add_res}   = {1'b0, acc_base} + {1'b0, lane_ext};
`ifdef SUM_SAT_EN
    acc_next           = (carry || ovf_q) ? '1 : add_res;
`else
    acc_next           = add_res;
`endif
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    sum_d     = sum_q;
    sum_id_d  = sum_id_q;
    sum_ovf_d = sum_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_ACC;
          gnt_d   = winner_oh;
          win_d   = winner;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          ptr_d   = ptr_next;
        end
      end
      ST_ACC: begin
        if (!win_req) begin
          // Requester withdrew: drop the partial sum, keep the last result.
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else begin
          acc_d = acc_next;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NSAMP - 1)) begin
            state_d   = ST_DONE;
            gnt_d     = '0;
            sum_d     = acc_next;
            sum_id_d  = win_q;
            sum_ovf_d = ovf_q | carry;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      ptr_q     <= '0;
      win_q     <= '0;
      sum_q     <= '0;
      sum_id_q  <= '0;
      sum_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      sum_q     <= sum_d;
      sum_id_q  <= sum_id_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.d_ack     = (state_q == ST_ACC);
  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.sum_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.sum_id    = sum_id_q;
  assign bus.sum_ovf   = sum_ovf_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(bus.gnt));
  a_gnt_only_acc: assert property (@(posedge clk) disable iff (!reset_n)
                                   (bus.gnt != '0) == (state_q == ST_ACC));

endmodule

// File: tb/tb_sum_rr_sched.sv
// Directed bench for sum_rr_sched: per-cycle compare against a transaction-level model plus literal anchors.
module tb_sum_rr_sched;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int NSAMP = 4;
  localparam int SW    = 8;
  localparam int MAXV  = (1 << SW) - 1;
`ifdef SUM_SAT_EN
  localparam int T3_SUM = 255;
`else
  localparam int T3_SUM = 44;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sum_rr_sched_if #(.NREQ(NREQ), .DW(DW), .SW(SW)) bus ();

  sum_rr_sched #(.NREQ(NREQ), .DW(DW), .NSAMP(NSAMP), .SW(SW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: phase 0 idle, 1..NSAMP collecting, NSAMP+1 result cycle.
  int            m_phase, m_ptr, m_win, m_total, m_id;
  logic [SW-1:0] m_sum;
  bit            m_ovf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_ptr = 0; m_win = 0; m_total = 0;
      m_sum = '0; m_id = 0; m_ovf = 1'b0;
    end else if (m_phase == 0) begin
      if (bus.req != '0) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (bus.req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
        m_ptr   = (m_win + 1) % NREQ;
        m_total = 0;
        m_phase = 1;
      end
    end else if (m_phase <= NSAMP) begin
      if (!bus.req[m_win]) begin
        m_phase = 0;
      end else begin
        m_total = m_total + int'(bus.d_in[m_win*DW +: DW]);
        if (m_phase == NSAMP) begin
`ifdef SUM_SAT_EN
          m_sum = (m_total > MAXV) ? SW'(MAXV) : SW'(m_total);
`else
          m_sum = SW'(m_total);
`endif
          m_ovf   = (m_total > MAXV);
          m_id    = m_win;
          m_phase = NSAMP + 1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end else begin
      m_phase = 0;
    end
  end

  bit            e_act;
  logic [NREQ-1:0] e_gnt;
  always @(negedge clk) begin
    if (chk_en) begin
      e_act = (m_phase >= 1) && (m_phase <= NSAMP);
      e_gnt = e_act ? NREQ'(1 << m_win) : '0;
      chk("gnt",       64'(bus.gnt),       64'(e_gnt));
      chk("d_ack",     64'(bus.d_ack),     64'(e_act));
      chk("ready",     64'(bus.ready),     64'(m_phase == 0));
      chk("sum_valid", 64'(bus.sum_valid), 64'(m_phase == NSAMP + 1));
      chk("sum",       64'(bus.sum),       64'(m_sum));
      chk("sum_id",    64'(bus.sum_id),    64'(m_id));
      chk("sum_ovf",   64'(bus.sum_ovf),   64'(m_ovf));
    end
  end

  // Observation log for the literal anchors.
  int            n_dack, n_valid, last_id;
  logic [SW-1:0] last_sum;
  bit            last_ovf;
  int            gnt_log[$];
  int            id_log[$];
  logic [NREQ-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (bus.d_ack === 1'b1) n_dack++;
    if (bus.sum_valid === 1'b1) begin
      n_valid++;
      last_sum = bus.sum;
      last_id  = int'(bus.sum_id);
      last_ovf = bus.sum_ovf;
      id_log.push_back(int'(bus.sum_id));
    end
    if (bus.gnt != '0 && prev_gnt == '0)
      for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) gnt_log.push_back(k);
    prev_gnt = bus.gnt;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    n_dack = 0; n_valid = 0; last_id = -1; last_sum = '0; last_ovf = 1'b0;
    gnt_log.delete(); id_log.delete();
  endtask

  task automatic set_lane(input int i, input int v);
    bus.d_in[i*DW +: DW] = DW'(v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},   64'(bus.gnt),       64'(0));
    chk({tag, "_dack"},  64'(bus.d_ack),     64'(0));
    chk({tag, "_ready"}, 64'(bus.ready),     64'(1));
    chk({tag, "_sum"},   64'(bus.sum),       64'(0));
    chk({tag, "_id"},    64'(bus.sum_id),    64'(0));
    chk({tag, "_vld"},   64'(bus.sum_valid), 64'(0));
    chk({tag, "_ovf"},   64'(bus.sum_ovf),   64'(0));
  endtask

  int exp_order[4] = '{0, 2, 0, 2};

  initial begin
    bus.req  = '0;
    bus.d_in = '0;
    tick(2);
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    chk_en  = 1'b1;
    clear_log();

    // Single requester, 10+20+30+40.
    bus.req = 4'b0001;
    tick(1);
    chk("t1_gnt", 64'(bus.gnt), 64'(4'b0001));
    set_lane(0, 10); tick(1);
    set_lane(0, 20); tick(1);
    set_lane(0, 30); tick(1);
    set_lane(0, 40); tick(1);
    bus.req = '0;
    tick(2);
    chk("t1_dack_cycles", 64'(n_dack), 64'(4));
    chk("t1_valid_cnt",   64'(n_valid), 64'(1));
    chk("t1_sum",         64'(last_sum), 64'(100));
    chk("t1_id",          64'(last_id),  64'(0));
    chk("t1_ovf",         64'(last_ovf), 64'(0));

    // Two requesters held from reset alternate 0,2,0,2.
    reset_n = 1'b0; tick(2); reset_n = 1'b1;
    clear_log();
    set_lane(0, 1); set_lane(2, 3);
    bus.req = 4'b0101;
    tick(23);
    bus.req = '0;
    tick(3);
    chk("t2_ngnt", 64'(gnt_log.size()), 64'(4));
    chk("t2_nres", 64'(id_log.size()),  64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("t2_gnt_order", 64'((k < gnt_log.size()) ? gnt_log[k] : -1), 64'(exp_order[k]));
      chk("t2_id_order",  64'((k < id_log.size())  ? id_log[k]  : -1), 64'(exp_order[k]));
    end
    chk("t2_last_sum", 64'(last_sum), 64'(12));

    // Overflow: 200+100+0+0.
    clear_log();
    bus.req = 4'b0010;
    tick(1);
    set_lane(1, 200); tick(1);
    set_lane(1, 100); tick(1);
    set_lane(1, 0);   tick(1);
    set_lane(1, 0);   tick(1);
    bus.req = '0;
    tick(2);
    chk("t3_sum", 64'(last_sum), 64'(T3_SUM));
    chk("t3_ovf", 64'(last_ovf), 64'(1));
    chk("t3_id",  64'(last_id),  64'(1));

    // Abort after two samples: previous result must survive.
    clear_log();
    bus.req = 4'b0010;
    tick(1);
    set_lane(1, 5); tick(1);
    set_lane(1, 6); tick(1);
    bus.req = '0;
    tick(1);
    @(negedge clk);
    chk("t4_gnt",   64'(bus.gnt),     64'(0));
    chk("t4_ready", 64'(bus.ready),   64'(1));
    chk("t4_sum",   64'(bus.sum),     64'(T3_SUM));
    chk("t4_ovf",   64'(bus.sum_ovf), 64'(1));
    tick(3);
    chk("t4_no_valid", 64'(n_valid), 64'(0));
    chk("t4_dack",     64'(n_dack),  64'(3));

    // Async reset in the third ACC cycle, then a fresh transaction.
    clear_log();
    set_lane(0, 7);
    bus.req = 4'b0001;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    bus.req = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    clear_log();
    set_lane(3, 1);
    bus.req = 4'b1000;
    tick(1);
    chk("t5_gnt", 64'(bus.gnt), 64'(4'b1000));
    tick(4);
    bus.req = '0;
    tick(2);
    chk("t5_sum",   64'(last_sum), 64'(4));
    chk("t5_id",    64'(last_id),  64'(3));
    chk("t5_valid", 64'(n_valid),  64'(1));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
